// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART RX frame parser: parser states,
// error codes, the default start-of-frame marker and a saturating increment.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHK     = 2'd3
  } frameState_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LEN  = 2'b01,
    ERR_CHK  = 2'b10,
    ERR_TMO  = 2'b11
  } errCode_e;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Loadable up-counter with clear and enable that raises tc_o once the count
// reaches TIMEOUT_CYCLES and then holds there until cleared or reloaded.
module uart_frame_timeout #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadVal_i,
  input  logic             enable_i,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == TC_VALUE);

  // Clear beats load beats count; the count parks at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = loadVal_i;
    end else if (enable_i && !tc_o) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Drain-side frame parser for the UART RX FIFO: hunts for SOF, parses
// LEN / payload / CHK, streams payload over valid/ready and reports status.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE       = SOF_BYTE_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         CNT_W          = 16
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Fifo_Empty,
  output logic       o_Fifo_Rd,
  input  logic [7:0] i_Fifo_Data,
  output logic [7:0] o_Byte,
  output logic       o_Byte_Valid,
  input  logic       i_Byte_Ready,
  output logic       o_Byte_Last,
  output logic       o_Frame_Ok,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
  output logic [7:0] o_Err_Count,
  output logic       o_Busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  frameState_e state_q, state_d;
  errCode_e    errCode_q, errCode_d;
  logic        rdPend_q, rdPend_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [7:0]  remain_q, remain_d;
  logic [7:0]  chk_q, chk_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [7:0]  errCount_q, errCount_d;

  logic capture;
  logic tmoTc;
  logic tmoAbort;
  logic tmoClear;
  logic tmoEnable;
  logic rdGo;

  assign capture   = rdPend_q;
  assign tmoAbort  = tmoTc && !capture && (state_q != HUNT);
  assign tmoClear  = capture || valid_q || (state_q == HUNT) || tmoAbort;
  assign tmoEnable = i_Fifo_Empty && !rdPend_q;

  // Reads are suppressed on the abort cycle so no byte is left in flight.
  assign rdGo = i_Reset && !i_Fifo_Empty && !rdPend_q && !valid_q && !tmoAbort;

  uart_frame_timeout #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (i_Clock),
    .rst_ni   (i_Reset),
    .clear_i  (tmoClear),
    .load_i   (1'b0),
    .loadVal_i({CNT_W{1'b0}}),
    .enable_i (tmoEnable),
    .tc_o     (tmoTc)
  );

  always_comb begin
    state_d    = state_q;
    rdPend_d   = rdGo;
    byte_d     = byte_q;
    valid_d    = valid_q;
    last_d     = last_q;
    remain_d   = remain_q;
    chk_d      = chk_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    errCode_d  = errCode_q;
    errCount_d = errCount_q;

    if (valid_q && i_Byte_Ready) begin
      valid_d  = 1'b0;
      last_d   = 1'b0;
      remain_d = remain_q - 8'd1;
      if (remain_q == 8'd1) begin
        state_d = CHK;
      end
    end

    if (tmoAbort) begin
      state_d    = HUNT;
      valid_d    = 1'b0;
      last_d     = 1'b0;
      err_d      = 1'b1;
      errCode_d  = ERR_TMO;
      errCount_d = satInc8(errCount_q);
    end else if (capture) begin
      case (state_q)
        HUNT: begin
          if (i_Fifo_Data == SOF_BYTE) begin
            chk_d   = 8'h00;
            state_d = LEN;
          end
        end
        LEN: begin
          if ((i_Fifo_Data == 8'h00) || (i_Fifo_Data > MAX_LEN_B)) begin
            err_d      = 1'b1;
            errCode_d  = ERR_LEN;
            errCount_d = satInc8(errCount_q);
            state_d    = HUNT;
          end else begin
            remain_d = i_Fifo_Data;
            chk_d    = i_Fifo_Data;
            state_d  = PAYLOAD;
          end
        end
        PAYLOAD: begin
          byte_d  = i_Fifo_Data;
          valid_d = 1'b1;
          last_d  = (remain_q == 8'd1);
          chk_d   = chk_q ^ i_Fifo_Data;
        end
        CHK: begin
          if (i_Fifo_Data == chk_q) begin
            ok_d      = 1'b1;
            errCode_d = ERR_NONE;
          end else begin
            err_d      = 1'b1;
            errCode_d  = ERR_CHK;
            errCount_d = satInc8(errCount_q);
          end
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q    <= HUNT;
      rdPend_q   <= 1'b0;
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      remain_q   <= 8'h00;
      chk_q      <= 8'h00;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      errCode_q  <= ERR_NONE;
      errCount_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      rdPend_q   <= rdPend_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      remain_q   <= remain_d;
      chk_q      <= chk_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      errCode_q  <= errCode_d;
      errCount_q <= errCount_d;
    end
  end

  assign o_Fifo_Rd    = rdGo;
  assign o_Byte       = byte_q;
  assign o_Byte_Valid = valid_q;
  assign o_Byte_Last  = last_q;
  assign o_Frame_Ok   = ok_q;
  assign o_Frame_Err  = err_q;
  assign o_Err_Code   = errCode_q;
  assign o_Err_Count  = errCount_q;
  assign o_Busy       = (state_q != HUNT);

endmodule
